// File: rtl/forwarding_controller_pkg.sv
// Shared types for the dual-issue forwarding controller.
//   fwd_mode_t    : 3-bit operand-mux select driven to the EX-stage muxes.
//   stage_entry_t : one lane's slot in the shadow pipeline {valid, rd, we, is_load}.
//   produces()    : producer-match rule shared by mode selection, load-use and pair checks.
package forwarding_controller_pkg;

  localparam int NUM_REGS = 32;
  localparam int REG_AW   = $clog2(NUM_REGS);

  typedef enum logic [2:0] {
    FWD_NORMAL         = 3'b000,
    FWD_BRANCH_EXECUTE = 3'b001,
    FWD_MEMORY_EXECUTE = 3'b010,
    FWD_BRANCH_MEMORY  = 3'b011,
    FWD_MEMORY_MEMORY  = 3'b100,
    FWD_BRANCH_WB      = 3'b101,
    FWD_MEMORY_WB      = 3'b110
  } fwd_mode_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              is_load;
  } stage_entry_t;

  // x0 is hardwired to zero, so a write to it never produces a value.
  function automatic logic produces(stage_entry_t e, logic [REG_AW-1:0] src);
    return e.valid && e.we && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/forwarding_controller_fwd_select.sv
// Combinational mode select for one EX operand.
//   src              : decode-stage source register
//   e_b/e_m          : producers that will sit in EX/MEM when the consumer is in EX
//   p1_b/p1_m        : producers that will sit in MEM/WB
//   p2_b/p2_m        : producers that will sit in WB
//   mode             : resulting 3-bit select
// Nearest stage wins; within a stage the Branch lane (younger of the pair) wins.
module forwarding_controller_fwd_select
  import forwarding_controller_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  stage_entry_t      e_b,
  input  stage_entry_t      e_m,
  input  stage_entry_t      p1_b,
  input  stage_entry_t      p1_m,
  input  stage_entry_t      p2_b,
  input  stage_entry_t      p2_m,
  output fwd_mode_t         mode
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    mode = FWD_NORMAL;
    if      (produces(e_b,  src)) mode = FWD_BRANCH_EXECUTE;
    else if (produces(e_m,  src)) mode = FWD_MEMORY_EXECUTE;
    else if (produces(p1_b, src)) mode = FWD_BRANCH_MEMORY;
    else if (produces(p1_m, src)) mode = FWD_MEMORY_MEMORY;
    else if (produces(p2_b, src)) mode = FWD_BRANCH_WB;
    else if (produces(p2_m, src)) mode = FWD_MEMORY_WB;
  end

endmodule

// File: rtl/forwarding_controller.sv
// Forwarding controller for the dual-issue pipeline (Branch lane + Memory lane).
// Ports:
//   clk, rst (sync, active-high), global_stall (hold all), flush (kill decode pair / EX entry)
//   dec_*            : decode pair sources, destinations, write enables, Memory-lane load flag
//   fwd_*_rs*        : registered 3-bit operand-mux selects, valid in the consumer's EX cycle
//   load_use_stall   : combinational decode stall request (load in EX feeding decode)
//   pair_dep         : combinational flag, Branch source == Memory rd inside the decode pair
// A shadow pipeline E/P1/P2/P3 mirrors the destination info of in-flight instructions.
module forwarding_controller
  import forwarding_controller_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              global_stall,
  input  logic              flush,
  input  logic              dec_valid_b,
  input  logic              dec_valid_m,
  input  logic [REG_AW-1:0] dec_rs1_b,
  input  logic [REG_AW-1:0] dec_rs2_b,
  input  logic [REG_AW-1:0] dec_rs1_m,
  input  logic [REG_AW-1:0] dec_rs2_m,
  input  logic [REG_AW-1:0] dec_rd_b,
  input  logic [REG_AW-1:0] dec_rd_m,
  input  logic              dec_we_b,
  input  logic              dec_we_m,
  input  logic              dec_is_load_m,
  output logic [2:0]        fwd_b_rs1,
  output logic [2:0]        fwd_b_rs2,
  output logic [2:0]        fwd_m_rs1,
  output logic [2:0]        fwd_m_rs2,
  output logic              load_use_stall,
  output logic              pair_dep
);

  stage_entry_t e_b,  e_m;
  stage_entry_t p1_b, p1_m;
  stage_entry_t p2_b, p2_m;
  stage_entry_t p3_b, p3_m;

  stage_entry_t dec_b, dec_m;

  fwd_mode_t nxt_b_rs1, nxt_b_rs2, nxt_m_rs1, nxt_m_rs2;
  fwd_mode_t mode_b_rs1, mode_b_rs2, mode_m_rs1, mode_m_rs2;

  logic load_hit;

  // Loads only issue in the Memory lane, so the Branch entry never carries is_load.
  assign dec_b = '{valid: dec_valid_b, rd: dec_rd_b, we: dec_we_b, is_load: 1'b0};
  assign dec_m = '{valid: dec_valid_m, rd: dec_rd_m, we: dec_we_m, is_load: dec_is_load_m};

  // Modes are decided one cycle early: what is in E now is in EX/MEM when
  // the consumer reaches EX, P1 lands in MEM/WB and P2 in WB.
  forwarding_controller_fwd_select u_sel_b_rs1 (
    .src(dec_rs1_b), .e_b(e_b), .e_m(e_m), .p1_b(p1_b), .p1_m(p1_m),
    .p2_b(p2_b), .p2_m(p2_m), .mode(nxt_b_rs1)
  );
  forwarding_controller_fwd_select u_sel_b_rs2 (
    .src(dec_rs2_b), .e_b(e_b), .e_m(e_m), .p1_b(p1_b), .p1_m(p1_m),
    .p2_b(p2_b), .p2_m(p2_m), .mode(nxt_b_rs2)
  );
  forwarding_controller_fwd_select u_sel_m_rs1 (
    .src(dec_rs1_m), .e_b(e_b), .e_m(e_m), .p1_b(p1_b), .p1_m(p1_m),
    .p2_b(p2_b), .p2_m(p2_m), .mode(nxt_m_rs1)
  );
  forwarding_controller_fwd_select u_sel_m_rs2 (
    .src(dec_rs2_m), .e_b(e_b), .e_m(e_m), .p1_b(p1_b), .p1_m(p1_m),
    .p2_b(p2_b), .p2_m(p2_m), .mode(nxt_m_rs2)
  );

  // A load in E has no data until MEM/WB, so any decode reader must wait one
  // cycle; afterwards it matches the load in P1 as Memory_Memory.
  always_comb begin
    load_hit = 1'b0;
    if (e_m.is_load) begin
      load_hit = (dec_valid_b && (produces(e_m, dec_rs1_b) || produces(e_m, dec_rs2_b))) ||
                 (dec_valid_m && (produces(e_m, dec_rs1_m) || produces(e_m, dec_rs2_m)));
    end
  end

  assign load_use_stall = load_hit && !flush;

  // Informational only; dec_m's valid bit is folded in by produces().
  assign pair_dep = !flush && dec_valid_b &&
                    (produces(dec_m, dec_rs1_b) || produces(dec_m, dec_rs2_b));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the shift P1<-E, P2<-P1 is order-independent.
    if (rst) begin
      e_b        <= '0;
      e_m        <= '0;
      p1_b       <= '0;
      p1_m       <= '0;
      p2_b       <= '0;
      p2_m       <= '0;
      p3_b       <= '0;
      p3_m       <= '0;
      mode_b_rs1 <= FWD_NORMAL;
      mode_b_rs2 <= FWD_NORMAL;
      mode_m_rs1 <= FWD_NORMAL;
      mode_m_rs2 <= FWD_NORMAL;
    end else if (!global_stall) begin
      p1_b <= e_b;
      p1_m <= e_m;
      p2_b <= p1_b;
      p2_m <= p1_m;
      p3_b <= p2_b;
      p3_m <= p2_m;
      if (flush || load_use_stall) begin
        e_b        <= '0;
        e_m        <= '0;
        mode_b_rs1 <= FWD_NORMAL;
        mode_b_rs2 <= FWD_NORMAL;
        mode_m_rs1 <= FWD_NORMAL;
        mode_m_rs2 <= FWD_NORMAL;
      end else begin
        e_b        <= dec_b;
        e_m        <= dec_m;
        mode_b_rs1 <= nxt_b_rs1;
        mode_b_rs2 <= nxt_b_rs2;
        mode_m_rs1 <= nxt_m_rs1;
        mode_m_rs2 <= nxt_m_rs2;
      end
    end
  end

  // The WB stage is tracked so the shadow mirrors the real pipeline, but it
  // never forwards: the register file writes before it is read.
  logic unused_p3;
  assign unused_p3 = ^{p3_b, p3_m};

  assign fwd_b_rs1 = mode_b_rs1;
  assign fwd_b_rs2 = mode_b_rs2;
  assign fwd_m_rs1 = mode_m_rs1;
  assign fwd_m_rs2 = mode_m_rs2;

endmodule
